// File: rtl/multi_buffer_writer.sv
// ============================================================================
// multi_buffer_writer : packs variable-byte beats into RAM words over credited buffers
// Rev 1.0
// ============================================================================
`default_nettype none

module multi_buffer_writer #(
  parameter int DATA_WIDTH    = 128,
  parameter int DATA_IN_WIDTH = 64,
  parameter int ADDR_WIDTH    = 10,
  parameter int BUFF_NUM      = 4
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [DATA_IN_WIDTH-1:0]               in_data,
  input  logic [$clog2(DATA_IN_WIDTH/8):0]       in_bytes,
  input  logic                                   in_last,
  input  logic                                   buf_release,
  output logic                                   write_en,
  output logic [ADDR_WIDTH+$clog2(BUFF_NUM)-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]                  data_out,
  output logic                                   buf_done,
  output logic [$clog2(BUFF_NUM)-1:0]            buf_done_idx
);

  localparam int W  = DATA_WIDTH / 8;
  localparam int B  = DATA_IN_WIDTH / 8;
  localparam int FW = $clog2(W) + 1;
  localparam int BW = $clog2(BUFF_NUM);
  localparam int CW = BW + 1;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    SPILL = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic [FW-1:0]           fill_q, fill_d;
  logic [CW-1:0]           credits_q, credits_d;
  logic [ADDR_WIDTH-1:0]   waddr_q;
  logic [BW-1:0]           bidx_q;
  logic                    write_en_q;
  logic [ADDR_WIDTH+BW-1:0] write_addr_q;
  logic [DATA_WIDTH-1:0]   data_out_q;
  logic                    buf_done_q;
  logic [BW-1:0]           buf_done_idx_q;

  logic [2*DATA_WIDTH-1:0] beat_ext;
  logic [2*DATA_WIDTH-1:0] packed_v;
  logic [FW-1:0]           total;
  logic [FW-1:0]           rem;
  logic                    full;
  logic                    take;
  logic                    emit;
  logic [DATA_WIDTH-1:0]   emit_data;
  logic                    last_word;
  logic                    complete;

  assign in_ready  = (state_q == RUN) && (credits_q != CW'(0));
  assign take      = in_valid & in_ready;
  assign last_word = (waddr_q == {ADDR_WIDTH{1'b1}});
  assign complete  = emit & last_word;

  // Bytes above in_bytes are masked so garbage never lands in the accumulator.
  always_comb begin
    beat_ext = '0;
    for (int i = 0; i < B; i++) begin
      if (i < int'(in_bytes)) beat_ext[i*8 +: 8] = in_data[i*8 +: 8];
    end
    packed_v = {{DATA_WIDTH{1'b0}}, acc_q} | (beat_ext << {fill_q, 3'b000});
    total    = fill_q + FW'(in_bytes);
    full     = (total >= FW'(W));
    rem      = full ? (total - FW'(W)) : total;
  end

  always_comb begin
    emit      = 1'b0;
    emit_data = packed_v[DATA_WIDTH-1:0];
    acc_d     = acc_q;
    fill_d    = fill_q;
    state_d   = state_q;
    if (state_q == SPILL) begin
      if (credits_q != CW'(0)) begin
        emit      = 1'b1;
        emit_data = acc_q;
        acc_d     = '0;
        fill_d    = '0;
        state_d   = RUN;
      end
    end else if (take) begin
      if (full) begin
        emit   = 1'b1;
        acc_d  = packed_v[2*DATA_WIDTH-1:DATA_WIDTH];
        fill_d = rem;
        if (in_last && (rem != FW'(0))) state_d = SPILL;
      end else if (in_last) begin
        emit   = (rem != FW'(0));
        acc_d  = '0;
        fill_d = '0;
      end else begin
        acc_d  = packed_v[DATA_WIDTH-1:0];
        fill_d = rem;
      end
    end
  end

  // A release and a completion in the same cycle cancel out.
  always_comb begin
    credits_d = credits_q;
    if (complete && !buf_release) begin
      credits_d = credits_q - CW'(1);
    end else if (!complete && buf_release && (credits_q != CW'(BUFF_NUM))) begin
      credits_d = credits_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= RUN;
      acc_q          <= '0;
      fill_q         <= '0;
      credits_q      <= CW'(BUFF_NUM);
      waddr_q        <= '0;
      bidx_q         <= '0;
      write_en_q     <= 1'b0;
      write_addr_q   <= '0;
      data_out_q     <= '0;
      buf_done_q     <= 1'b0;
      buf_done_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      credits_q  <= credits_d;
      write_en_q <= emit;
      buf_done_q <= complete;
      if (emit) begin
        write_addr_q <= {bidx_q, waddr_q};
        data_out_q   <= emit_data;
        waddr_q      <= waddr_q + ADDR_WIDTH'(1);
        if (last_word) begin
          bidx_q         <= bidx_q + BW'(1);
          buf_done_idx_q <= bidx_q;
        end
      end
    end
  end

  assign write_en     = write_en_q;
  assign write_addr   = write_addr_q;
  assign data_out     = data_out_q;
  assign buf_done     = buf_done_q;
  assign buf_done_idx = buf_done_idx_q;

endmodule

`default_nettype wire
